// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_BR    = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  // Major opcodes (IR[6:0]) understood by this control unit
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU operand selects
  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_A   = 1'b1;
  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  // PC source select: live ALU result or the registered ALUOut
  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  // True for every opcode that EX knows how to sequence (ECALL is handled in ID)
  function automatic logic op_defined(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: op_defined = 1'b1;
      default:                    op_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// Cycle and retired-instruction counters for the multi-cycle control unit.
// Latency: counts become visible one cycle after the counted event.
// Backpressure: none; counters wrap modulo 2^CNT_W.
module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_retire,
  input  logic             i_active,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_instret
);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;

  // Count active cycles and retire events; synchronous clear on reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (i_active) r_cycle   <= r_cycle + 1'b1;
      if (i_retire) r_instret <= r_instret + 1'b1;
    end
  end

  assign o_cycle_count = r_cycle;
  assign o_instret     = r_instret;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM driving all datapath enables and mux selects.
// Latency: outputs combinational from state/inputs; R/I 4, LD 5, ST 4, BNT 3, BT 4, JAL(R) 3 cycles.
// Backpressure: stalls in IF/MEM while mem_ready=0; watchdog forces FAULT after MEM_WAIT_MAX waits.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             a_write,
  output logic             b_write,
  output logic             aluout_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_source,
  output logic             is_halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  localparam int WD_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_WAIT_MAX - 1);

  state_t          r_state;
  state_t          w_next;
  logic [WD_W-1:0] r_wd;
  logic            w_mem_phase;
  logic            w_wd_expire;
  logic            w_retire;
  logic            w_active;

  assign w_mem_phase = (r_state == S_IF) || (r_state == S_MEM);
  // mem_ready has priority over an expiring watchdog
  assign w_wd_expire = (MEM_WAIT_MAX != 0) && (r_wd == WD_LAST) && !mem_ready;
  assign is_halted   = (r_state == S_HALT);
  assign fault       = (r_state == S_FAULT);
  assign w_active    = !(is_halted || fault);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

  // Watchdog: count consecutive unready memory cycles, clear otherwise
  always_ff @(posedge clk) begin
    if (reset)                           r_wd <= '0;
    else if (w_mem_phase && !mem_ready)  r_wd <= r_wd + 1'b1;
    else                                 r_wd <= '0;
  end

  // Next-state and control decode
  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    pc_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    a_write      = 1'b0;
    b_write      = 1'b0;
    aluout_write = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_B;
    alu_op       = ALU_ADD;
    pc_source    = PCSRC_ALU;
    case (r_state)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready)        w_next = S_ID;
        else if (w_wd_expire) w_next = S_FAULT;
      end
      S_ID: begin
        a_write      = 1'b1;
        b_write      = 1'b1;
        alu_src_b    = SRCB_4;
        aluout_write = 1'b1;
        if (opcode == OP_ECALL)     w_next = S_HALT;
        else if (!op_defined(opcode)) w_next = S_FAULT;
        else                        w_next = S_EX;
      end
      S_EX: begin
        case (opcode)
          OP_R, OP_I: begin
            alu_src_a    = SRCA_A;
            alu_src_b    = (opcode == OP_I) ? SRCB_IMM : SRCB_B;
            alu_op       = ALU_FUNCT;
            aluout_write = 1'b1;
            w_next       = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a    = SRCA_A;
            alu_src_b    = SRCB_IMM;
            aluout_write = 1'b1;
            w_next       = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = SRCA_A;
            alu_op    = ALU_BR;
            if (!bcond) begin
              // Not taken: ALUOut still holds PC+4 from ID
              pc_write  = 1'b1;
              pc_source = PCSRC_ALUOUT;
              w_retire  = 1'b1;
              w_next    = S_IF;
            end else begin
              w_next = S_BR;
            end
          end
          OP_JAL, OP_JALR: begin
            // Link value PC+4 sits in ALUOut; ALU forms the jump target
            alu_src_a = (opcode == OP_JALR) ? SRCA_A : SRCA_PC;
            alu_src_b = SRCB_IMM;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            w_retire  = 1'b1;
            w_next    = S_IF;
          end
          default: w_next = S_FAULT;
        endcase
      end
      S_BR: begin
        alu_src_b = SRCB_IMM;
        pc_write  = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_IF;
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          mem_read  = 1'b1;
          mdr_write = mem_ready;
          if (mem_ready)        w_next = S_WB;
          else if (w_wd_expire) w_next = S_FAULT;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            alu_src_b = SRCB_4;
            pc_write  = 1'b1;
            w_retire  = 1'b1;
            w_next    = S_IF;
          end else if (w_wd_expire) begin
            w_next = S_FAULT;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        alu_src_b  = SRCB_4;
        pc_write   = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_IF;
      end
      S_HALT, S_FAULT: w_next = r_state;
      default:         w_next = S_FAULT;
    endcase
  end

  mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_retire      (w_retire),
    .i_active      (w_active),
    .o_cycle_count (cycle_count),
    .o_instret     (instret)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with hand-computed control vectors.
// Latency: checks every cycle of each instruction sequence.
// Backpressure: exercises IF/MEM stalls and the watchdog.
module tb_mc_control_fsm;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_ECALL  = 7'b1110011;
  localparam logic [6:0] T_BAD    = 7'b1111111;

  // Order: pc_write i_or_d mem_read mem_write ir_write mdr_write a_write b_write
  //        aluout_write reg_write mem_to_reg alu_src_a alu_src_b[1:0] alu_op[1:0] pc_source
  localparam logic [16:0] OFF      = 17'b0;
  localparam logic [16:0] IF_W     = 17'b0_0_1_0_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] IF_R     = 17'b0_0_1_0_1_0_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] ID_V     = 17'b0_0_0_0_0_0_1_1_1_0_0_0_01_00_0;
  localparam logic [16:0] EX_R     = 17'b0_0_0_0_0_0_0_0_1_0_0_1_00_10_0;
  localparam logic [16:0] EX_LS    = 17'b0_0_0_0_0_0_0_0_1_0_0_1_10_00_0;
  localparam logic [16:0] EX_BNT   = 17'b1_0_0_0_0_0_0_0_0_0_0_1_00_01_1;
  localparam logic [16:0] EX_BT    = 17'b0_0_0_0_0_0_0_0_0_0_0_1_00_01_0;
  localparam logic [16:0] EX_JAL   = 17'b1_0_0_0_0_0_0_0_0_1_0_0_10_00_0;
  localparam logic [16:0] EX_JALR  = 17'b1_0_0_0_0_0_0_0_0_1_0_1_10_00_0;
  localparam logic [16:0] BR_V     = 17'b1_0_0_0_0_0_0_0_0_0_0_0_10_00_0;
  localparam logic [16:0] MEM_LW_W = 17'b0_1_1_0_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] MEM_LW_R = 17'b0_1_1_0_0_1_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] MEM_SW_W = 17'b0_1_0_1_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] MEM_SW_R = 17'b1_1_0_1_0_0_0_0_0_0_0_0_01_00_0;
  localparam logic [16:0] WB_R     = 17'b1_0_0_0_0_0_0_0_0_1_0_0_01_00_0;
  localparam logic [16:0] WB_LW    = 17'b1_0_0_0_0_0_0_0_0_1_1_0_01_00_0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'b0;
  logic        bcond = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write;
  logic        a_write, b_write, aluout_write, reg_write, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        pc_source, is_halted, fault;
  logic [31:0] cycle_count, instret;
  logic [16:0] ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write, a_write, b_write,
                aluout_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_WAIT_MAX(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mdr_write(mdr_write), .a_write(a_write), .b_write(b_write),
    .aluout_write(aluout_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .is_halted(is_halted), .fault(fault), .cycle_count(cycle_count), .instret(instret)
  );

  // Apply inputs for one cycle at the falling edge and let outputs settle
  task automatic cyc(input logic [6:0] op, input logic bc, input logic mr);
    @(negedge clk);
    opcode = op; bcond = bc; mem_ready = mr;
    #1;
  endtask

  // One synchronous reset edge; leaves the bench just after that edge, state IF
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; bcond = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ctl !== IF_W) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, IF_W); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle got %0d want 0", cycle_count); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
    checks++; if ({is_halted, fault} !== 2'b00) begin errors++; $display("FAIL reset_status got %b want 00", {is_halted, fault}); end
  endtask

  task automatic test_add();
    logic [16:0] exp [4];
    exp = '{IF_R, ID_V, EX_R, WB_R};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(T_R, 1'b0, 1'b1);
      checks++; if (ctl !== exp[i]) begin errors++; $display("FAIL add[%0d] got %b want %b", i, ctl, exp[i]); end
    end
    cyc(T_R, 1'b0, 1'b0);
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL add_instret got %0d want 1", instret); end
    checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL add_cycles got %0d want 4", cycle_count); end
  endtask

  task automatic test_load_stall();
    logic [16:0] exp [10];
    logic        mr  [10];
    int irp, mdp;
    exp = '{IF_W, IF_W, IF_W, IF_R, ID_V, EX_LS, MEM_LW_W, MEM_LW_W, MEM_LW_R, WB_LW};
    mr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    irp = 0; mdp = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(T_LOAD, 1'b0, mr[i]);
      irp += int'(ir_write);
      mdp += int'(mdr_write);
      checks++; if (ctl !== exp[i]) begin errors++; $display("FAIL load[%0d] got %b want %b", i, ctl, exp[i]); end
    end
    cyc(T_LOAD, 1'b0, 1'b0);
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL load_instret got %0d want 1", instret); end
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL load_cycles got %0d want 10", cycle_count); end
    checks++; if (irp !== 1) begin errors++; $display("FAIL load_ir_pulses got %0d want 1", irp); end
    checks++; if (mdp !== 1) begin errors++; $display("FAIL load_mdr_pulses got %0d want 1", mdp); end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(T_R, 1'b0, 1'b0);
      checks++; if ({fault, ctl} !== {1'b0, IF_W}) begin errors++; $display("FAIL wd_wait[%0d] got %b want %b", i, {fault, ctl}, {1'b0, IF_W}); end
    end
    cyc(T_R, 1'b0, 1'b0);
    checks++; if ({fault, is_halted, ctl} !== {2'b10, OFF}) begin errors++; $display("FAIL wd_fault got %b want %b", {fault, is_halted, ctl}, {2'b10, OFF}); end
    checks++; if (cycle_count !== 32'd8) begin errors++; $display("FAIL wd_cycles got %0d want 8", cycle_count); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL wd_instret got %0d want 0", instret); end
    for (int i = 0; i < 3; i++) cyc(T_R, 1'b0, 1'b1);
    checks++; if ({fault, cycle_count} !== {1'b1, 32'd8}) begin errors++; $display("FAIL wd_frozen got fault=%b cycles=%0d want 1/8", fault, cycle_count); end
    // mem_ready in the expiring cycle must win
    do_reset();
    for (int i = 0; i < 8; i++) cyc(T_R, 1'b0, (i == 7));
    cyc(T_R, 1'b0, 1'b1);
    checks++; if ({fault, ctl} !== {1'b0, ID_V}) begin errors++; $display("FAIL wd_race got %b want %b", {fault, ctl}, {1'b0, ID_V}); end
  endtask

  task automatic test_branch();
    logic [16:0] exp_nt [3];
    logic [16:0] exp_t  [4];
    exp_nt = '{IF_R, ID_V, EX_BNT};
    exp_t  = '{IF_R, ID_V, EX_BT, BR_V};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(T_BRANCH, 1'b0, 1'b1);
      checks++; if (ctl !== exp_nt[i]) begin errors++; $display("FAIL bnt[%0d] got %b want %b", i, ctl, exp_nt[i]); end
    end
    cyc(T_BRANCH, 1'b0, 1'b0);
    checks++; if ({instret, cycle_count} !== {32'd1, 32'd3}) begin errors++; $display("FAIL bnt_counts got %0d/%0d want 1/3", instret, cycle_count); end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(T_BRANCH, 1'b1, 1'b1);
      checks++; if (ctl !== exp_t[i]) begin errors++; $display("FAIL bt[%0d] got %b want %b", i, ctl, exp_t[i]); end
    end
    cyc(T_BRANCH, 1'b1, 1'b0);
    checks++; if ({instret, cycle_count} !== {32'd1, 32'd4}) begin errors++; $display("FAIL bt_counts got %0d/%0d want 1/4", instret, cycle_count); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp [10];
    logic [6:0]  ops [10];
    exp = '{IF_R, ID_V, EX_JAL, IF_R, ID_V, EX_JALR, IF_R, ID_V, EX_LS, MEM_SW_R};
    ops = '{T_JAL, T_JAL, T_JAL, T_JALR, T_JALR, T_JALR, T_STORE, T_STORE, T_STORE, T_STORE};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(ops[i], 1'b0, 1'b1);
      checks++; if (ctl !== exp[i]) begin errors++; $display("FAIL b2b[%0d] got %b want %b", i, ctl, exp[i]); end
    end
    cyc(T_R, 1'b0, 1'b0);
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL b2b_instret got %0d want 3", instret); end
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL b2b_cycles got %0d want 10", cycle_count); end
  endtask

  task automatic test_halt_fault();
    do_reset();
    cyc(T_ECALL, 1'b0, 1'b1);
    cyc(T_ECALL, 1'b0, 1'b1);
    checks++; if (ctl !== ID_V) begin errors++; $display("FAIL ecall_id got %b want %b", ctl, ID_V); end
    for (int i = 0; i < 6; i++) begin
      cyc(7'($urandom), 1'($urandom), 1'($urandom));
      checks++; if ({is_halted, fault, ctl} !== {2'b10, OFF}) begin errors++; $display("FAIL halt[%0d] got %b want %b", i, {is_halted, fault, ctl}, {2'b10, OFF}); end
    end
    checks++; if ({instret, cycle_count} !== {32'd0, 32'd2}) begin errors++; $display("FAIL halt_counts got %0d/%0d want 0/2", instret, cycle_count); end
    do_reset();
    checks++; if ({is_halted, ctl} !== {1'b0, IF_W}) begin errors++; $display("FAIL halt_reset got %b want %b", {is_halted, ctl}, {1'b0, IF_W}); end
    cyc(T_BAD, 1'b0, 1'b1);
    cyc(T_BAD, 1'b0, 1'b1);
    cyc(T_BAD, 1'b0, 1'b1);
    checks++; if ({fault, is_halted, ctl} !== {2'b10, OFF}) begin errors++; $display("FAIL illegal got %b want %b", {fault, is_halted, ctl}, {2'b10, OFF}); end
    do_reset();
    checks++; if ({fault, ctl} !== {1'b0, IF_W}) begin errors++; $display("FAIL fault_reset got %b want %b", {fault, ctl}, {1'b0, IF_W}); end
  endtask

  task automatic test_reset_mid_store();
    logic [16:0] exp [5];
    logic        mr  [5];
    exp = '{IF_R, ID_V, EX_LS, MEM_SW_W, MEM_SW_W};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(T_STORE, 1'b0, mr[i]);
      checks++; if (ctl !== exp[i]) begin errors++; $display("FAIL st_stall[%0d] got %b want %b", i, ctl, exp[i]); end
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (ctl !== IF_W) begin errors++; $display("FAIL st_reset_ctl got %b want %b", ctl, IF_W); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL st_reset_memwrite got %b want 0", mem_write); end
    checks++; if ({instret, cycle_count} !== {32'd0, 32'd0}) begin errors++; $display("FAIL st_reset_counts got %0d/%0d want 0/0", instret, cycle_count); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_stall();
    test_watchdog();
    test_branch();
    test_back_to_back();
    test_halt_fault();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
